// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Parametrised up/down modulo counter with synchronous load and registered
// compare/wrap flags. Every flag is a registered output, so each reports the
// count value held before the clock edge that sets it.
//
// Parameters:
//   WIDTH     - counter width in bits (2..32)
//   MAX       - highest count value; the modulus is MAX+1 (1 <= MAX <= 2**WIDTH-1)
//   RESET_VAL - value loaded into count on reset (<= MAX)
//
// Ports:
//   clk      in   clock, rising edge active
//   reset    in   asynchronous active-low reset
//   en       in   count enable
//   up       in   direction: 1 = up, 0 = down
//   load     in   synchronous load request (priority over en)
//   load_val in   value to load, clamped to MAX
//   cmp_val  in   compare value for match
//   count    out  current count
//   match    out  registered (count == cmp_val), one cycle behind count
//   wrap     out  one-cycle pulse on an overflow or underflow event
//
// Build option:
//   MOD_COUNTER_SATURATE_EN - when defined, overflow holds count at MAX and
//   underflow holds it at 0; wrap still pulses on every attempted event.
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    // Values above MAX are not representable in the count sequence.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
        return (v > MAX) ? MAX : v;
    endfunction

    // Count value that follows an overflow event.
    function automatic logic [WIDTH-1:0] overflow_val();
`ifdef MOD_COUNTER_SATURATE_EN
        return MAX;
`else
        return ZERO;
`endif
    endfunction

    // Count value that follows an underflow event.
    function automatic logic [WIDTH-1:0] underflow_val();
`ifdef MOD_COUNTER_SATURATE_EN
        return ZERO;
`else
        return MAX;
`endif
    endfunction

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = clamp_to_max(load_val);
        end else if (en) begin
            if (up) begin
                if (count == MAX) begin
                    count_next = overflow_val();
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end else begin
                if (count == ZERO) begin
                    count_next = underflow_val();
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count - ONE;
                end
            end
        end
    end

    // match looks at the pre-edge count, so it trails count by one cycle
    // regardless of en/load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_VAL;
            match <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            match <= (count == cmp_val);
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] cmp_val = 8'hFF;

    logic [7:0] count_a, count_b;
    logic       match_a, match_b, wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: WIDTH=8 with default MAX (255); b: WIDTH=8, MAX=9
    mod_counter #(.WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .cmp_val(cmp_val),
        .count(count_a), .match(match_a), .wrap(wrap_a)
    );

    mod_counter #(.WIDTH(8), .MAX(8'd9)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .cmp_val(cmp_val),
        .count(count_b), .match(match_b), .wrap(wrap_b)
    );

    typedef struct {
        int cnt;
        bit m;
        bit w;
    } model_t;

    typedef struct {
        model_t a;
        model_t b;
    } exp_t;

    exp_t   exp_q[$];
    model_t st_a, st_b;

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural reference: modulo arithmetic over MAX+1 states.
    function automatic model_t mstep(model_t s, int mx, bit ld, int lv, bit e, bit u, int cv);
        model_t r;
        r.m   = (s.cnt == cv);
        r.w   = 1'b0;
        r.cnt = s.cnt;
        if (ld) begin
            r.cnt = (lv < mx) ? lv : mx;
        end else if (e) begin
            if (u) begin
                r.w = (s.cnt == mx);
`ifdef MOD_COUNTER_SATURATE_EN
                r.cnt = r.w ? mx : s.cnt + 1;
`else
                r.cnt = (s.cnt + 1) % (mx + 1);
`endif
            end else begin
                r.w = (s.cnt == 0);
`ifdef MOD_COUNTER_SATURATE_EN
                r.cnt = r.w ? 0 : s.cnt - 1;
`else
                r.cnt = (s.cnt + mx) % (mx + 1);
`endif
            end
        end
        return r;
    endfunction

    // Drive one cycle of stimulus, push the expected post-edge state, then
    // pop and compare once the DUT has registered it.
    task automatic drive(input bit ld, input int lv, input bit e, input bit u, input int cv,
                         input string tag);
        exp_t x;
        exp_t got;
        load     = ld;
        load_val = 8'(lv);
        en       = e;
        up       = u;
        cmp_val  = 8'(cv);
        x.a  = mstep(st_a, 255, ld, lv, e, u, cv);
        x.b  = mstep(st_b, 9, ld, lv, e, u, cv);
        st_a = x.a;
        st_b = x.b;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_val({tag, ".a.count"}, int'(count_a), got.a.cnt);
        check_val({tag, ".a.match"}, int'(match_a), int'(got.a.m));
        check_val({tag, ".a.wrap"},  int'(wrap_a),  int'(got.a.w));
        check_val({tag, ".b.count"}, int'(count_b), got.b.cnt);
        check_val({tag, ".b.match"}, int'(match_b), int'(got.b.m));
        check_val({tag, ".b.wrap"},  int'(wrap_b),  int'(got.b.w));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".a.count"}, int'(count_a), 0);
        check_val({tag, ".a.match"}, int'(match_a), 0);
        check_val({tag, ".a.wrap"},  int'(wrap_a),  0);
        check_val({tag, ".b.count"}, int'(count_b), 0);
        check_val({tag, ".b.match"}, int'(match_b), 0);
        check_val({tag, ".b.wrap"},  int'(wrap_b),  0);
    endtask

    initial begin
        st_a = '{cnt: 0, m: 1'b0, w: 1'b0};
        st_b = '{cnt: 0, m: 1'b0, w: 1'b0};

        // Reset held across a couple of edges
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        reset = 1'b1;

        // Load 0x37 (b clamps to 9), then assert reset between edges
        drive(1, 8'h37, 0, 0, 255, "load37");
        check_val("pre_rst.a.count", int'(count_a), 8'h37);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        st_a = '{cnt: 0, m: 1'b0, w: 1'b0};
        st_b = '{cnt: 0, m: 1'b0, w: 1'b0};
        @(negedge clk);
        reset = 1'b1;

        // Three counting edges after release
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 255, "up3");
        check_val("up3.final", int'(count_a), 3);

        // Count up from 0 with cmp_val=5: b wraps at 9, both match one cycle after 5
        drive(1, 0, 0, 0, 5, "ld0");
        for (int i = 0; i < 12; i++) drive(0, 0, 1, 1, 5, "up12");
        check_val("up12.b.final", int'(count_b), 2);

        // Load above MAX clamps, then count down through 0 -> MAX
        drive(1, 15, 0, 0, 255, "ld15");
        check_val("ld15.b.clamp", int'(count_b), 9);
        for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 255, "dn10");
        check_val("dn10.b.final", int'(count_b), 9);

        // Load and overflow event on the same edge: load wins, no wrap
        drive(1, 9, 0, 0, 255, "ld9");
        drive(1, 4, 1, 1, 255, "ld_vs_ovf");
        check_val("ld_vs_ovf.b.wrap", int'(wrap_b), 0);

        // Overflow from 8 (saturate or wrap depending on build)
        drive(1, 8, 0, 0, 255, "ld8");
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 255, "ovf3");

        // Full-width wrap on a, compare held at a constant count
        drive(1, 254, 0, 0, 254, "ld254");
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 254, "a_ovf");
        drive(1, 7, 0, 0, 7, "ld7");
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 7, "hold7");

        // cmp_val above MAX on b: it can never match
        for (int i = 0; i < 15; i++) drive(0, 0, 1, 1, 12, "cmp_gt_max");

        // Randomised mix
        for (int i = 0; i < 60; i++)
            drive(($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
